// File: rtl/ofs_plat_ccip_mmio_rd_pkg.sv
// Shared types and helpers for the CCI-P MMIO read tracker.
// Ring entries carry everything needed to format and tag the eventual response.
package ofs_plat_ccip_mmio_rd_pkg;

   localparam int MMIO_RD_ADDR_WIDTH = 16;
   localparam int MMIO_RD_TID_WIDTH  = 9;
   localparam logic [63:0] MMIO_RD_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      LEN_4B = 1'b0,
      LEN_8B = 1'b1
   } t_mmio_rd_len;

   typedef struct packed {
      logic [MMIO_RD_ADDR_WIDTH-1:0] addr;
      t_mmio_rd_len                  len;
      logic [MMIO_RD_TID_WIDTH-1:0]  tid;
   } t_mmio_rd_entry;

   // Only encoding 0 is a 4-byte read; anything else is served as 8 bytes.
   function automatic t_mmio_rd_len mmio_rd_decode_len(input logic [1:0] len);
      return (len == 2'd0) ? LEN_4B : LEN_8B;
   endfunction

   function automatic logic [63:0] mmio_rd_format(input t_mmio_rd_entry e,
                                                  input logic [63:0] data);
      logic [31:0] sel;
      sel = e.addr[0] ? data[63:32] : data[31:0];
      return (e.len == LEN_8B) ? data : {sel, sel};
   endfunction

endpackage

// File: rtl/ofs_plat_ccip_mmio_rd_ring.sv
// Three-pointer request ring: accept (wr), issue on AR (ar), retire on R or timeout (rd).
// The issue-side outputs look one cycle ahead so the parent can register AR directly.
module ofs_plat_ccip_mmio_rd_ring
   import ofs_plat_ccip_mmio_rd_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 64
)
(
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_push,
   input  t_mmio_rd_entry i_push_entry,
   input  logic           i_issue,
   input  logic           i_retire,
   output logic           o_full,
   output logic           o_has_unissued,
   output logic           o_has_inflight,
   output t_mmio_rd_entry o_head_issue,
   output t_mmio_rd_entry o_head_retire
);

   localparam int IDX_W = $clog2(MAX_OUTSTANDING);
   typedef logic [IDX_W:0] t_ptr;

   t_mmio_rd_entry r_mem [MAX_OUTSTANDING];
   t_ptr           r_wr_ptr;
   t_ptr           r_ar_ptr;
   t_ptr           r_rd_ptr;

   logic w_do_push;
   t_ptr w_wr_ptr_nxt;
   t_ptr w_ar_ptr_nxt;

   assign o_full       = ((r_wr_ptr - r_rd_ptr) == t_ptr'(MAX_OUTSTANDING));
   assign w_do_push    = i_push & ~o_full;
   assign w_wr_ptr_nxt = r_wr_ptr + t_ptr'(w_do_push);
   assign w_ar_ptr_nxt = r_ar_ptr + t_ptr'(i_issue);

   // Lookahead view: what the AR register should hold after this edge.
   // When the issue head is the slot being written right now, forward the new entry.
   assign o_has_unissued = (w_ar_ptr_nxt != w_wr_ptr_nxt);
   assign o_head_issue   = (w_ar_ptr_nxt == r_wr_ptr) ? i_push_entry
                                                      : r_mem[w_ar_ptr_nxt[IDX_W-1:0]];

   assign o_has_inflight = (r_rd_ptr != r_ar_ptr);
   assign o_head_retire  = r_mem[r_rd_ptr[IDX_W-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_entry;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_ar_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_ar_ptr <= w_ar_ptr_nxt;
         r_rd_ptr <= r_rd_ptr + t_ptr'(i_retire);
      end
   end

endmodule

// File: rtl/ofs_plat_ccip_mmio_rd_tracker.sv
// Buffers CCI-P MMIO reads, issues them as AXI-lite AR, and answers every tid in order,
// substituting an all-ones response when the AFU fails to return R in time.
module ofs_plat_ccip_mmio_rd_tracker
   import ofs_plat_ccip_mmio_rd_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 64,
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 64,
   parameter int TID_WIDTH       = 9,
   parameter int TIMEOUT_CYCLES  = 4096
)
(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_mmio_rd_valid,
   input  logic [ADDR_WIDTH-1:0] i_mmio_rd_addr,
   input  logic [1:0]            i_mmio_rd_len,
   input  logic [TID_WIDTH-1:0]  i_mmio_rd_tid,
   output logic                  o_ar_valid,
   input  logic                  i_ar_ready,
   output logic [ADDR_WIDTH+1:0] o_ar_addr,
   output logic [2:0]            o_ar_prot,
   input  logic                  i_r_valid,
   output logic                  o_r_ready,
   input  logic [DATA_WIDTH-1:0] i_r_data,
   input  logic [1:0]            i_r_resp,
   output logic                  o_rsp_valid,
   output logic [TID_WIDTH-1:0]  o_rsp_tid,
   output logic [63:0]           o_rsp_data,
   output logic                  o_err_overflow,
   output logic                  o_err_timeout,
   output logic                  o_err_unexpected_r
);

   localparam int DROP_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   t_mmio_rd_entry w_push_entry;
   t_mmio_rd_entry w_head_issue;
   t_mmio_rd_entry w_head_retire;
   logic           w_full;
   logic           w_has_unissued;
   logic           w_has_inflight;
   logic           w_ar_fire;
   logic           w_r_fire;
   logic           w_drop_beat;
   logic           w_retire_beat;
   logic           w_unexpected;
   logic           w_timeout;
   logic           w_unused_ok;

   logic                  r_ar_valid;
   logic [ADDR_WIDTH+1:0] r_ar_addr;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic [DROP_W-1:0]     r_drop_pending;
   logic                  r_rsp_valid;
   logic [TID_WIDTH-1:0]  r_rsp_tid;
   logic [63:0]           r_rsp_data;
   logic                  r_err_overflow;
   logic                  r_err_timeout;
   logic                  r_err_unexpected_r;

   assign w_push_entry.addr = i_mmio_rd_addr;
   assign w_push_entry.len  = mmio_rd_decode_len(i_mmio_rd_len);
   assign w_push_entry.tid  = i_mmio_rd_tid;

   ofs_plat_ccip_mmio_rd_ring #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) ring (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_push         (i_mmio_rd_valid),
      .i_push_entry   (w_push_entry),
      .i_issue        (w_ar_fire),
      .i_retire       (w_retire_beat | w_timeout),
      .o_full         (w_full),
      .o_has_unissued (w_has_unissued),
      .o_has_inflight (w_has_inflight),
      .o_head_issue   (w_head_issue),
      .o_head_retire  (w_head_retire)
   );

   // Beats owed to reads that already timed out are swallowed before any retirement.
   assign w_ar_fire     = r_ar_valid & i_ar_ready;
   assign w_r_fire      = i_r_valid & o_r_ready;
   assign w_drop_beat   = w_r_fire & (r_drop_pending != '0);
   assign w_retire_beat = w_r_fire & ~w_drop_beat & w_has_inflight;
   assign w_unexpected  = w_r_fire & ~w_drop_beat & ~w_has_inflight;
   assign w_timeout     = TMO_EN & w_has_inflight & ~w_retire_beat & (r_tmo_cnt == TMO_LAST);

   assign o_ar_valid         = r_ar_valid;
   assign o_ar_addr          = r_ar_addr;
   assign o_ar_prot          = 3'b000;
   assign o_r_ready          = ~i_reset;
   assign o_rsp_valid        = r_rsp_valid;
   assign o_rsp_tid          = r_rsp_tid;
   assign o_rsp_data         = r_rsp_data;
   assign o_err_overflow     = r_err_overflow;
   assign o_err_timeout      = r_err_timeout;
   assign o_err_unexpected_r = r_err_unexpected_r;

   assign w_unused_ok = &{1'b0, i_r_resp, w_head_issue, w_head_retire};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ar_valid <= 1'b0;
         r_ar_addr  <= '0;
      end else begin
         r_ar_valid <= w_has_unissued;
         if (w_has_unissued) begin
            r_ar_addr <= {w_head_issue.addr, 2'b00};
         end
      end
   end

   // The timeout clock restarts whenever the retire head moves or nothing is in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tmo_cnt      <= '0;
         r_drop_pending <= '0;
      end else begin
         if (!TMO_EN || w_retire_beat || w_timeout || !w_has_inflight) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         r_drop_pending <= r_drop_pending + DROP_W'(w_timeout) - DROP_W'(w_drop_beat);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_retire_beat | w_timeout;
         if (w_retire_beat) begin
            r_rsp_tid  <= w_head_retire.tid;
            r_rsp_data <= mmio_rd_format(w_head_retire, i_r_data);
         end else if (w_timeout) begin
            r_rsp_tid  <= w_head_retire.tid;
            r_rsp_data <= MMIO_RD_TIMEOUT_DATA;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_err_overflow     <= 1'b0;
         r_err_timeout      <= 1'b0;
         r_err_unexpected_r <= 1'b0;
      end else begin
         r_err_overflow     <= r_err_overflow | (i_mmio_rd_valid & w_full);
         r_err_timeout      <= r_err_timeout | w_timeout;
         r_err_unexpected_r <= r_err_unexpected_r | w_unexpected;
      end
   end

endmodule

// File: tb/tb_ofs_plat_ccip_mmio_rd_tracker.sv
// Scoreboard bench for the MMIO read tracker: expected responses are queued as R beats
// (or timeouts) are provoked, and the monitor's captured responses are popped against them.
module tb_ofs_plat_ccip_mmio_rd_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        mmioRdValid;
   logic [15:0] mmioRdAddr;
   logic [1:0]  mmioRdLen;
   logic [8:0]  mmioRdTid;
   logic        arValid;
   logic        arReady;
   logic [17:0] arAddr;
   logic [2:0]  arProt;
   logic        rValid;
   logic        rReady;
   logic [63:0] rData;
   logic [1:0]  rResp;
   logic        rspValid;
   logic [8:0]  rspTid;
   logic [63:0] rspData;
   logic        errOverflow;
   logic        errTimeout;
   logic        errUnexpectedR;

   typedef struct packed {
      logic [8:0]  tid;
      logic [63:0] data;
   } t_rsp;

   t_rsp expQ[$];
   t_rsp obsQ[$];
   int   nCompared   = 0;
   int   nMismatched = 0;

   always #5 clk = ~clk;

   ofs_plat_ccip_mmio_rd_tracker #(
      .MAX_OUTSTANDING (64),
      .ADDR_WIDTH      (16),
      .DATA_WIDTH      (64),
      .TID_WIDTH       (9),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_mmio_rd_valid    (mmioRdValid),
      .i_mmio_rd_addr     (mmioRdAddr),
      .i_mmio_rd_len      (mmioRdLen),
      .i_mmio_rd_tid      (mmioRdTid),
      .o_ar_valid         (arValid),
      .i_ar_ready         (arReady),
      .o_ar_addr          (arAddr),
      .o_ar_prot          (arProt),
      .i_r_valid          (rValid),
      .o_r_ready          (rReady),
      .i_r_data           (rData),
      .i_r_resp           (rResp),
      .o_rsp_valid        (rspValid),
      .o_rsp_tid          (rspTid),
      .o_rsp_data         (rspData),
      .o_err_overflow     (errOverflow),
      .o_err_timeout      (errTimeout),
      .o_err_unexpected_r (errUnexpectedR)
   );

   // Capture every response on the falling edge; tasks act 1ns later to avoid races.
   always @(negedge clk) begin
      if (rspValid === 1'b1) obsQ.push_back({rspTid, rspData});
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic sendRead(input logic [8:0] tid, input logic [15:0] addr, input logic [1:0] len);
      mmioRdValid = 1'b1;
      mmioRdTid   = tid;
      mmioRdAddr  = addr;
      mmioRdLen   = len;
      waitCycle();
      mmioRdValid = 1'b0;
   endtask

   task automatic driveR(input logic [63:0] data);
      rValid = 1'b1;
      rData  = data;
      waitCycle();
      rValid = 1'b0;
   endtask

   task automatic applyReset(input int cycles);
      reset       = 1'b1;
      mmioRdValid = 1'b0;
      rValid      = 1'b0;
      arReady     = 1'b0;
      repeat (cycles) waitCycle();
      reset = 1'b0;
      expQ.delete();
      obsQ.delete();
   endtask

   function automatic logic [63:0] modelData(input logic [15:0] addr, input logic [1:0] len,
                                             input logic [63:0] d);
      logic [31:0] half;
      half = addr[0] ? d[63:32] : d[31:0];
      return (len == 2'd0) ? {half, half} : d;
   endfunction

   task automatic test_reset();
      reset = 1'b1; mmioRdValid = 1'b0; mmioRdAddr = '0; mmioRdLen = '0; mmioRdTid = '0;
      arReady = 1'b0; rValid = 1'b0; rData = '0; rResp = 2'b00;
      repeat (3) waitCycle();
      nCompared++;
      if ({arValid, rspValid, rspTid, rspData, errOverflow, errTimeout, errUnexpectedR, rReady} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_state: got arV=%b rspV=%b tid=%h data=%h errs=%b%b%b rReady=%b, expected all 0",
                  arValid, rspValid, rspTid, rspData, errOverflow, errTimeout, errUnexpectedR, rReady);
      end
      reset = 1'b0;
      waitCycle();
      nCompared++;
      if (rReady !== 1'b1 || arValid !== 1'b0 || arProt !== 3'b000) begin
         nMismatched++;
         $display("[TB] FAIL post_reset: got rReady=%b arValid=%b arProt=%b, expected 1 0 000", rReady, arValid, arProt);
      end
   endtask

   task automatic test_single_8b();
      t_rsp e, o;
      int   waitCnt;
      arReady = 1'b1;
      sendRead(9'h05, 16'h0010, 2'd1);
      nCompared++;
      if (arValid !== 1'b1 || arAddr !== 18'h00040) begin
         nMismatched++;
         $display("[TB] FAIL single_ar: got valid=%b addr=%h, expected 1 00040", arValid, arAddr);
      end
      repeat (3) waitCycle();
      nCompared++;
      if (arValid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL single_ar_done: got arValid=%b, expected 0", arValid);
      end
      expQ.push_back({9'h05, 64'h1122334455667788});
      driveR(64'h1122334455667788);
      nCompared++;
      if (rspValid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL single_rsp_latency: got rspValid=%b one cycle after R, expected 1", rspValid);
      end
      waitCycle();
      nCompared++;
      if (rspValid !== 1'b0 || rspData !== 64'h1122334455667788) begin
         nMismatched++;
         $display("[TB] FAIL single_rsp_hold: got valid=%b data=%h, expected 0 1122334455667788", rspValid, rspData);
      end
      waitCnt = 0;
      while (obsQ.size() < expQ.size() && waitCnt < 20) begin waitCycle(); waitCnt++; end
      nCompared++;
      if (obsQ.size() != expQ.size()) begin
         nMismatched++;
         $display("[TB] FAIL single_count: got %0d responses, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL single_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_4b_formatting();
      logic [15:0] addrs [3];
      logic [1:0]  lens  [3];
      logic [63:0] datas [3];
      t_rsp e, o;
      int   waitCnt;
      addrs[0] = 16'h0011; lens[0] = 2'd0; datas[0] = 64'hAAAAAAAA_BBBBBBBB;
      addrs[1] = 16'h0012; lens[1] = 2'd0; datas[1] = 64'h01234567_89ABCDEF;
      addrs[2] = 16'h0013; lens[2] = 2'd3; datas[2] = 64'hCAFEF00D_DEADBEEF;
      arReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sendRead(9'(9'h06 + i), addrs[i], lens[i]);
         waitCycle();
         expQ.push_back({9'(9'h06 + i), modelData(addrs[i], lens[i], datas[i])});
         driveR(datas[i]);
      end
      nCompared++;
      if (expQ[0].data !== 64'hAAAAAAAA_AAAAAAAA) begin
         nMismatched++;
         $display("[TB] FAIL 4b_model_odd: got %h, expected AAAAAAAAAAAAAAAA", expQ[0].data);
      end
      waitCnt = 0;
      while (obsQ.size() < expQ.size() && waitCnt < 20) begin waitCycle(); waitCnt++; end
      nCompared++;
      if (obsQ.size() != expQ.size()) begin
         nMismatched++;
         $display("[TB] FAIL 4b_count: got %0d responses, expected %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL 4b_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_back_to_back();
      t_rsp e, o;
      int   arIssued, rIdx, cyc, waitCnt;
      arReady = 1'b0;
      for (int i = 0; i < 64; i++) sendRead(9'(9'h040 + i), 16'(16'h0100 + i), 2'd1);
      nCompared++;
      if (errOverflow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_no_overflow_at_64: got errOverflow=%b, expected 0", errOverflow);
      end
      sendRead(9'h1AA, 16'h01FF, 2'd1);
      nCompared++;
      if (errOverflow !== 1'b1 || arValid !== 1'b1 || arAddr !== 18'h00400) begin
         nMismatched++;
         $display("[TB] FAIL b2b_overflow: got err=%b arValid=%b arAddr=%h, expected 1 1 00400", errOverflow, arValid, arAddr);
      end
      arIssued = 0; rIdx = 0; cyc = 0;
      while ((arIssued < 64 || rIdx < 64) && cyc < 300) begin
         if (rIdx < arIssued) begin
            rValid = 1'b1;
            rData  = {32'hD0D0_0000 | 32'(rIdx), 32'h0000_1000 + 32'(rIdx)};
            expQ.push_back({9'(9'h040 + rIdx), rData});
            rIdx++;
         end else begin
            rValid = 1'b0;
         end
         arReady = 1'b1;
         if (arIssued < 64) begin
            nCompared++;
            if (arValid !== 1'b1 || arAddr !== 18'({16'(16'h0100 + arIssued), 2'b00})) begin
               nMismatched++;
               $display("[TB] FAIL b2b_ar[%0d]: got valid=%b addr=%h, expected 1 %h", arIssued, arValid, arAddr,
                        18'({16'(16'h0100 + arIssued), 2'b00}));
            end
            arIssued++;
         end
         waitCycle();
         cyc++;
      end
      rValid = 1'b0;
      nCompared++;
      if (arValid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_dropped_not_issued: got arValid=%b after 64 ARs, expected 0", arValid);
      end
      waitCnt = 0;
      while (obsQ.size() < expQ.size() && waitCnt < 40) begin waitCycle(); waitCnt++; end
      repeat (3) waitCycle();
      nCompared++;
      if (obsQ.size() != 64 || expQ.size() != 64) begin
         nMismatched++;
         $display("[TB] FAIL b2b_count: got %0d responses, expected 64 (queued %0d)", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL b2b_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_timeout();
      t_rsp e, o;
      int   waited;
      arReady = 1'b1;
      sendRead(9'h01F, 16'h0020, 2'd1);
      expQ.push_back({9'h01F, 64'hFFFF_FFFF_FFFF_FFFF});
      waited = 0;
      while (obsQ.size() == 0 && waited < 40) begin waitCycle(); waited++; end
      nCompared++;
      if (waited != 17) begin
         nMismatched++;
         $display("[TB] FAIL timeout_latency: got response after %0d cycles, expected 17", waited);
      end
      nCompared++;
      if (errTimeout !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL timeout_flag: got errTimeout=%b, expected 1", errTimeout);
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL timeout_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete();
      driveR(64'h5555_5555_5555_5555);
      repeat (3) waitCycle();
      nCompared++;
      if (obsQ.size() != 0 || errUnexpectedR !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL timeout_late_r: got %0d responses errUnexpectedR=%b, expected 0 0", obsQ.size(), errUnexpectedR);
      end
      obsQ.delete();
      sendRead(9'h020, 16'h0021, 2'd1);
      waitCycle();
      expQ.push_back({9'h020, 64'h2020_2020_0BAD_F00D});
      driveR(64'h2020_2020_0BAD_F00D);
      repeat (3) waitCycle();
      nCompared++;
      if (obsQ.size() != 1) begin
         nMismatched++;
         $display("[TB] FAIL timeout_next_count: got %0d responses, expected 1", obsQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL timeout_next_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_r_on_timeout();
      t_rsp e, o;
      arReady = 1'b1;
      sendRead(9'h033, 16'h0031, 2'd1);
      repeat (16) waitCycle();
      expQ.push_back({9'h033, 64'h3333_4444_5555_6666});
      driveR(64'h3333_4444_5555_6666);
      nCompared++;
      if (rspValid !== 1'b1 || rspData !== 64'h3333_4444_5555_6666) begin
         nMismatched++;
         $display("[TB] FAIL race_rsp_now: got valid=%b data=%h, expected 1 3333444455556666", rspValid, rspData);
      end
      repeat (20) waitCycle();
      nCompared++;
      if (obsQ.size() != 1 || errTimeout !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL race_no_timeout: got %0d responses errTimeout=%b, expected 1 0", obsQ.size(), errTimeout);
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
         if (o !== e) begin
            nMismatched++;
            $display("[TB] FAIL race_rsp: got tid=%h data=%h, expected tid=%h data=%h", o.tid, o.data, e.tid, e.data);
         end
      end
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_reset_midop();
      arReady = 1'b1;
      for (int i = 0; i < 3; i++) sendRead(9'(9'h101 + i), 16'(16'h0200 + i), 2'd1);
      waitCycle();
      reset = 1'b1;
      waitCycle();
      nCompared++;
      if (arValid !== 1'b0 || rspValid !== 1'b0 || {errOverflow, errTimeout, errUnexpectedR} !== 3'b000) begin
         nMismatched++;
         $display("[TB] FAIL midreset_state: got arValid=%b rspValid=%b errs=%b%b%b, expected 0 0 000",
                  arValid, rspValid, errOverflow, errTimeout, errUnexpectedR);
      end
      waitCycle();
      reset = 1'b0;
      obsQ.delete();
      for (int i = 0; i < 3; i++) driveR(64'h0BAD_0000_0000_0000 + 64'(i));
      repeat (4) waitCycle();
      nCompared++;
      if (obsQ.size() != 0 || errUnexpectedR !== 1'b1 || arValid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midreset_after: got %0d responses errUnexpectedR=%b arValid=%b, expected 0 1 0",
                  obsQ.size(), errUnexpectedR, arValid);
      end
   endtask

   initial begin
      test_reset();
      test_single_8b();
      test_4b_formatting();
      test_back_to_back();
      test_timeout();
      applyReset(2);
      test_r_on_timeout();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
